// File: rtl/clk_pkg.sv
// Shared types and defaults for the reset sequencer.
// State encoding, cycle defaults and counter width helper.
package clk_pkg;

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    STABLE   = 3'd1,
    SDRAM_UP = 3'd2,
    CORE_UP  = 3'd3,
    RUN      = 3'd4,
    SOFT     = 3'd5,
    FAULT    = 3'd6
  } seq_state_t;

  localparam int DEF_SYNC_STAGES       = 2;
  localparam int DEF_LOCK_STABLE_CYC   = 1024;
  localparam int DEF_SOFT_RST_CYC      = 64;
  localparam int DEF_SDRAM_TIMEOUT_CYC = 1048576;

  function automatic int cnt_width(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Level synchronizer, STAGES flops deep, async active-low clear.
// Intended for slow level signals crossing into this clock domain.
module sync_ff
  import clk_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer: PLL lock -> SDRAM reset release -> core release.
// Define RST_SEQ_TIMEOUT_EN to enable the SDRAM init timeout / FAULT state.
module rst_seq
  import clk_pkg::*;
#(
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE_CYC   = DEF_LOCK_STABLE_CYC,
  parameter int SOFT_RST_CYC      = DEF_SOFT_RST_CYC,
  parameter int SDRAM_TIMEOUT_CYC = DEF_SDRAM_TIMEOUT_CYC
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sdram_init_done,
  input  logic       soft_rst_req,
  output logic       sdram_rst,
  output logic       core_rst,
  output logic       ce_gate,
  output logic [2:0] seq_state,
  output logic       fault
);

  localparam int CW = cnt_width(LOCK_STABLE_CYC, SOFT_RST_CYC,
                                SDRAM_TIMEOUT_CYC);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] SOFT_LAST = CW'(SOFT_RST_CYC - 1);
`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LAST = CW'(SDRAM_TIMEOUT_CYC - 1);
`endif

  seq_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_run;
  logic          locked_s, init_s;
  logic          sdram_rst_q, core_rst_q, ce_gate_q;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk_i  (clk_sys),
    .rst_ni (rst_n),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_init (
    .clk_i  (clk_sys),
    .rst_ni (rst_n),
    .d_i    (sdram_init_done),
    .q_o    (init_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_run = 1'b0;
    unique case (state_q)
      HOLD: begin
        if (locked_s) state_d = STABLE;
      end
      STABLE: begin
        if (!locked_s)               state_d = HOLD;
        else if (cnt_q == LOCK_LAST) state_d = SDRAM_UP;
        else                         cnt_run = 1'b1;
      end
      SDRAM_UP: begin
        if (!locked_s)    state_d = HOLD;
        else if (init_s)  state_d = CORE_UP;
`ifdef RST_SEQ_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) state_d = FAULT;
        else                        cnt_run = 1'b1;
`endif
      end
      CORE_UP: begin
        if (!locked_s) state_d = HOLD;
        else           state_d = RUN;
      end
      RUN: begin
        if (!locked_s)         state_d = HOLD;
        else if (soft_rst_req) state_d = SOFT;
      end
      SOFT: begin
        if (!locked_s)               state_d = HOLD;
        else if (cnt_q == SOFT_LAST) state_d = RUN;
        else                         cnt_run = 1'b1;
      end
      FAULT: begin
        if (!locked_s) state_d = HOLD;
      end
      default: state_d = HOLD;
    endcase
    // shared counter restarts on every state change
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(cnt_run);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      sdram_rst_q <= 1'b1;
      core_rst_q  <= 1'b1;
      ce_gate_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sdram_rst_q <= state_d inside {HOLD, STABLE, FAULT};
      core_rst_q  <= (state_d != RUN);
      ce_gate_q   <= (state_d == RUN);
    end
  end

`ifdef RST_SEQ_TIMEOUT_EN
  logic fault_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_q | (state_d == FAULT);
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign sdram_rst = sdram_rst_q;
  assign core_rst  = core_rst_q;
  assign ce_gate   = ce_gate_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: expected snapshots queued per scenario.
// Timeout scenario runs only when RST_SEQ_TIMEOUT_EN is defined.
module tb_rst_seq;
  import clk_pkg::*;

  localparam int LOCK  = 16;
  localparam int SOFTC = 8;
  localparam int TMO   = 32;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       sdram_init_done;
  logic       soft_rst_req;
  logic       sdram_rst;
  logic       core_rst;
  logic       ce_gate;
  logic [2:0] seq_state;
  logic       fault;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    string      nm;
    logic [2:0] st;
    logic       sr;
    logic       cr;
    logic       ce;
    logic       f;
  } exp_t;

  exp_t sb[$];

  always #5 clk_sys = ~clk_sys;

  rst_seq #(
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYC   (LOCK),
    .SOFT_RST_CYC      (SOFTC),
    .SDRAM_TIMEOUT_CYC (TMO)
  ) dut (
    .clk_sys         (clk_sys),
    .rst_n           (rst_n),
    .pll_locked      (pll_locked),
    .sdram_init_done (sdram_init_done),
    .soft_rst_req    (soft_rst_req),
    .sdram_rst       (sdram_rst),
    .core_rst        (core_rst),
    .ce_gate         (ce_gate),
    .seq_state       (seq_state),
    .fault           (fault)
  );

  function automatic exp_t mk(int cyc, string nm,
                              seq_state_t st, logic f);
    exp_t e;
    e.cyc = cyc;
    e.nm  = nm;
    e.st  = st;
    e.f   = f;
    e.sr  = st inside {HOLD, STABLE, FAULT};
    e.cr  = (st != RUN);
    e.ce  = (st == RUN);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    pll_locked      = 1'b0;
    sdram_init_done = 1'b0;
    soft_rst_req    = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    sb.push_back(mk(0, "reset", HOLD, 1'b0));
    e = sb.pop_front();
    checks++;
    if ({seq_state, sdram_rst, core_rst, ce_gate, fault} !==
        {e.st, e.sr, e.cr, e.ce, e.f}) begin
      errors++;
      $display("FAIL %s: st/sr/cr/ce/f got %0d/%b/%b/%b/%b want %0d/%b/%b/%b/%b",
               e.nm, seq_state, sdram_rst, core_rst, ce_gate, fault,
               e.st, e.sr, e.cr, e.ce, e.f);
    end
  endtask

  task automatic test_power_up();
    exp_t e;
    do_reset();
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    sb.push_back(mk(2,  "pu_hold",       HOLD,     1'b0));
    sb.push_back(mk(3,  "pu_stable",     STABLE,   1'b0));
    sb.push_back(mk(18, "pu_stable_end", STABLE,   1'b0));
    sb.push_back(mk(19, "pu_sdram_up",   SDRAM_UP, 1'b0));
    sb.push_back(mk(31, "pu_wait_init",  SDRAM_UP, 1'b0));
    sb.push_back(mk(32, "pu_core_up",    CORE_UP,  1'b0));
    sb.push_back(mk(33, "pu_run",        RUN,      1'b0));
    sb.push_back(mk(40, "pu_run_hold",   RUN,      1'b0));
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 29) sdram_init_done = 1'b1;
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        checks++;
        if ({seq_state, sdram_rst, core_rst, ce_gate, fault} !==
            {e.st, e.sr, e.cr, e.ce, e.f}) begin
          errors++;
          $display("FAIL %s: st/sr/cr/ce/f got %0d/%b/%b/%b/%b want %0d/%b/%b/%b/%b",
                   e.nm, seq_state, sdram_rst, core_rst, ce_gate, fault,
                   e.st, e.sr, e.cr, e.ce, e.f);
        end
      end
    end
  endtask

  task automatic test_soft_reset();
    exp_t e;
    soft_rst_req = 1'b1;
    sb.push_back(mk(1,  "soft_enter", SOFT, 1'b0));
    sb.push_back(mk(5,  "soft_mid",   SOFT, 1'b0));
    sb.push_back(mk(8,  "soft_last",  SOFT, 1'b0));
    sb.push_back(mk(9,  "soft_exit",  RUN,  1'b0));
    sb.push_back(mk(12, "soft_run",   RUN,  1'b0));
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) soft_rst_req = 1'b0;
      if (c == 4) soft_rst_req = 1'b1;
      if (c == 5) soft_rst_req = 1'b0;
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        checks++;
        if ({seq_state, sdram_rst, core_rst, ce_gate, fault} !==
            {e.st, e.sr, e.cr, e.ce, e.f}) begin
          errors++;
          $display("FAIL %s: st/sr/cr/ce/f got %0d/%b/%b/%b/%b want %0d/%b/%b/%b/%b",
                   e.nm, seq_state, sdram_rst, core_rst, ce_gate, fault,
                   e.st, e.sr, e.cr, e.ce, e.f);
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    exp_t e;
    pll_locked = 1'b0;
    sb.push_back(mk(2,  "ll_still_run", RUN,      1'b0));
    sb.push_back(mk(3,  "ll_hold",      HOLD,     1'b0));
    sb.push_back(mk(7,  "ll_relock_w",  HOLD,     1'b0));
    sb.push_back(mk(8,  "ll_stable",    STABLE,   1'b0));
    sb.push_back(mk(23, "ll_stable_e",  STABLE,   1'b0));
    sb.push_back(mk(24, "ll_sdram_up",  SDRAM_UP, 1'b0));
    sb.push_back(mk(25, "ll_core_up",   CORE_UP,  1'b0));
    sb.push_back(mk(26, "ll_run",       RUN,      1'b0));
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (c == 2) soft_rst_req = 1'b1;
      if (c == 3) soft_rst_req = 1'b0;
      if (c == 5) pll_locked = 1'b1;
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        checks++;
        if ({seq_state, sdram_rst, core_rst, ce_gate, fault} !==
            {e.st, e.sr, e.cr, e.ce, e.f}) begin
          errors++;
          $display("FAIL %s: st/sr/cr/ce/f got %0d/%b/%b/%b/%b want %0d/%b/%b/%b/%b",
                   e.nm, seq_state, sdram_rst, core_rst, ce_gate, fault,
                   e.st, e.sr, e.cr, e.ce, e.f);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(0, "async_rst", HOLD, 1'b0));
    e = sb.pop_front();
    checks++;
    if ({seq_state, sdram_rst, core_rst, ce_gate, fault} !==
        {e.st, e.sr, e.cr, e.ce, e.f}) begin
      errors++;
      $display("FAIL %s: st/sr/cr/ce/f got %0d/%b/%b/%b/%b want %0d/%b/%b/%b/%b",
               e.nm, seq_state, sdram_rst, core_rst, ce_gate, fault,
               e.st, e.sr, e.cr, e.ce, e.f);
    end
    tick();
  endtask

  task automatic test_lock_glitch();
    exp_t e;
    do_reset();
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    sb.push_back(mk(13, "lg_pre",      STABLE,   1'b0));
    sb.push_back(mk(14, "lg_lag",      STABLE,   1'b0));
    sb.push_back(mk(15, "lg_hold",     HOLD,     1'b0));
    sb.push_back(mk(16, "lg_restart",  STABLE,   1'b0));
    sb.push_back(mk(19, "lg_no_early", STABLE,   1'b0));
    sb.push_back(mk(31, "lg_last",     STABLE,   1'b0));
    sb.push_back(mk(32, "lg_sdram_up", SDRAM_UP, 1'b0));
    sb.push_back(mk(35, "lg_core_up",  CORE_UP,  1'b0));
    sb.push_back(mk(36, "lg_run",      RUN,      1'b0));
    for (int c = 1; c <= 36; c++) begin
      tick();
      if (c == 12) pll_locked = 1'b0;
      if (c == 13) pll_locked = 1'b1;
      if (c == 32) sdram_init_done = 1'b1;
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        checks++;
        if ({seq_state, sdram_rst, core_rst, ce_gate, fault} !==
            {e.st, e.sr, e.cr, e.ce, e.f}) begin
          errors++;
          $display("FAIL %s: st/sr/cr/ce/f got %0d/%b/%b/%b/%b want %0d/%b/%b/%b/%b",
                   e.nm, seq_state, sdram_rst, core_rst, ce_gate, fault,
                   e.st, e.sr, e.cr, e.ce, e.f);
        end
      end
    end
  endtask

`ifdef RST_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    do_reset();
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    sb.push_back(mk(19, "to_sdram_up", SDRAM_UP, 1'b0));
    sb.push_back(mk(50, "to_last",     SDRAM_UP, 1'b0));
    sb.push_back(mk(51, "to_fault",    FAULT,    1'b1));
    sb.push_back(mk(60, "to_late_ini", FAULT,    1'b1));
    sb.push_back(mk(62, "to_lag",      FAULT,    1'b1));
    sb.push_back(mk(63, "to_ll_hold",  HOLD,     1'b1));
    for (int c = 1; c <= 63; c++) begin
      tick();
      if (c == 52) sdram_init_done = 1'b1;
      if (c == 60) pll_locked = 1'b0;
      while (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        checks++;
        if ({seq_state, sdram_rst, core_rst, ce_gate, fault} !==
            {e.st, e.sr, e.cr, e.ce, e.f}) begin
          errors++;
          $display("FAIL %s: st/sr/cr/ce/f got %0d/%b/%b/%b/%b want %0d/%b/%b/%b/%b",
                   e.nm, seq_state, sdram_rst, core_rst, ce_gate, fault,
                   e.st, e.sr, e.cr, e.ce, e.f);
        end
      end
    end
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(0, "to_rst_clr", HOLD, 1'b0));
    e = sb.pop_front();
    checks++;
    if ({seq_state, sdram_rst, core_rst, ce_gate, fault} !==
        {e.st, e.sr, e.cr, e.ce, e.f}) begin
      errors++;
      $display("FAIL %s: st/sr/cr/ce/f got %0d/%b/%b/%b/%b want %0d/%b/%b/%b/%b",
               e.nm, seq_state, sdram_rst, core_rst, ce_gate, fault,
               e.st, e.sr, e.cr, e.ce, e.f);
    end
    tick();
  endtask
`endif

  initial begin
    rst_n           = 1'b0;
    pll_locked      = 1'b0;
    sdram_init_done = 1'b0;
    soft_rst_req    = 1'b0;
    test_reset();
    test_power_up();
    test_soft_reset();
    test_lock_loss();
    test_async_reset();
    test_lock_glitch();
`ifdef RST_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
